// File: rtl/sm4_encryptor_pkg.sv
// Shared constants and types for the SM4 encryptor front end.
//   group_size_p       : width of one SM4 block / key
//   word_width_p       : width of the input word streams (divides group_size_p)
//   words_per_group_lp : number of words packed into one group
package sm4_encryptor_pkg;

    localparam int group_size_p       = 128;
    localparam int word_width_p       = 32;
    localparam int words_per_group_lp = group_size_p / word_width_p;

    typedef enum logic {S_FILL, S_SEND} sm4_packer_state_e;

    typedef logic [group_size_p-1:0] sm4_group_t;

endpackage

// File: rtl/sm4_word_assembler.sv
// Packs a stream of words into one group, big-endian (first word in the top
// slot). The first word of each group clears the other slots, so slots that
// a short group never writes read back as zero.
//   clk_i, reset_i : clock, synchronous active-low reset
//   wr_i           : accept word_i this cycle
//   word_i         : incoming word
//   last_i         : this word closes the group early
//   empty_o        : no words of the current group collected yet
//   full_o         : this write lands in the final slot
//   close_o        : this write closes the group (final slot or last_i)
//   group_o        : group contents including this cycle's write
module sm4_word_assembler
    import sm4_encryptor_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    wr_i,
    input  logic [word_width_p-1:0] word_i,
    input  logic                    last_i,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    close_o,
    output sm4_group_t              group_o
);

    localparam int cnt_w_lp = $clog2(words_per_group_lp);
    typedef logic [cnt_w_lp-1:0] cnt_t;
    localparam cnt_t last_slot_lp = cnt_t'(words_per_group_lp - 1);

    logic [words_per_group_lp-1:0][word_width_p-1:0] slots_q, slots_d;
    cnt_t cnt_q, cnt_d;

    always_comb begin
        slots_d = slots_q;
        cnt_d   = cnt_q;
        full_o  = wr_i && (cnt_q == last_slot_lp);
        close_o = wr_i && (last_i || (cnt_q == last_slot_lp));
        if (wr_i) begin
            if (cnt_q == '0) slots_d = '0;
            // Packed index last_slot is the MSB slot, giving big-endian order.
            slots_d[last_slot_lp - cnt_q] = word_i;
            cnt_d = close_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            slots_q <= '0;
            cnt_q   <= '0;
        end else begin
            slots_q <= slots_d;
            cnt_q   <= cnt_d;
        end
    end

    assign empty_o = (cnt_q == '0);
    assign group_o = slots_d;

endmodule

// File: rtl/sm4_group_packer.sv
// Feeder for the SM4 core: packs data and key word streams into 128-bit
// groups and hands {content, key, mode} to the core with valid/ready.
//   clk_i, reset_i        : clock, synchronous active-low reset
//   word_i/_v_i/_last_i   : data word stream; last closes a short group
//   mode_i                : 1=decrypt, taken from the first word of a group
//   word_ready_o          : data handshake ready
//   key_word_i/_v_i       : key word stream
//   key_word_ready_o      : key handshake ready
//   content_o, key_o      : packed group and committed key to core
//   encode_or_decode_o    : mode of the presented group
//   v_o / ready_i         : group handshake with the core
//   invalid_cache_o       : one-cycle pulse after a key commit
//   padded_o              : presented group was zero-padded
//   group_cnt_o           : groups handed off since reset (wraps)
module sm4_group_packer
    import sm4_encryptor_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [word_width_p-1:0] word_i,
    input  logic                    word_v_i,
    input  logic                    word_last_i,
    input  logic                    mode_i,
    output logic                    word_ready_o,
    input  logic [word_width_p-1:0] key_word_i,
    input  logic                    key_word_v_i,
    output logic                    key_word_ready_o,
    output sm4_group_t              content_o,
    output sm4_group_t              key_o,
    output logic                    encode_or_decode_o,
    output logic                    v_o,
    input  logic                    ready_i,
    output logic                    invalid_cache_o,
    output logic                    padded_o,
    output logic [7:0]              group_cnt_o
);

    sm4_packer_state_e state_q;
    sm4_group_t        content_q, key_q;
    logic              key_loaded_q, mode_q, enc_q, padded_q, v_q, inv_q;
    logic [7:0]        group_cnt_q;

    logic       w_acc, k_acc;
    logic       d_empty, d_full, d_close;
    logic       k_empty, k_full, k_close;
    sm4_group_t d_group, k_group;

    // Key words only enter between groups; data waits for a complete key and
    // yields to a key word presented in the same cycle.
    assign key_word_ready_o = (state_q == S_FILL) && d_empty;
    assign word_ready_o     = (state_q == S_FILL) && key_loaded_q && k_empty && !key_word_v_i;
    assign w_acc            = word_v_i && word_ready_o;
    assign k_acc            = key_word_v_i && key_word_ready_o;

    sm4_word_assembler u_data (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .wr_i    (w_acc),
        .word_i  (word_i),
        .last_i  (word_last_i),
        .empty_o (d_empty),
        .full_o  (d_full),
        .close_o (d_close),
        .group_o (d_group)
    );

    sm4_word_assembler u_key (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .wr_i    (k_acc),
        .word_i  (key_word_i),
        .last_i  (1'b0),
        .empty_o (k_empty),
        .full_o  (k_full),
        .close_o (k_close),
        .group_o (k_group)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= S_FILL;
            content_q    <= '0;
            key_q        <= '0;
            key_loaded_q <= 1'b0;
            mode_q       <= 1'b0;
            enc_q        <= 1'b0;
            padded_q     <= 1'b0;
            v_q          <= 1'b0;
            inv_q        <= 1'b0;
            group_cnt_q  <= '0;
        end else begin
            inv_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    // Key stream has no early close, so commit needs all slots.
                    if (k_close && k_full) begin
                        key_q        <= k_group;
                        key_loaded_q <= 1'b1;
                        inv_q        <= 1'b1;
                    end
                    if (w_acc && d_empty) mode_q <= mode_i;
                    if (d_close) begin
                        content_q <= d_group;
                        // A one-word group closes on its first word.
                        enc_q     <= d_empty ? mode_i : mode_q;
                        padded_q  <= !d_full;
                        v_q       <= 1'b1;
                        state_q   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (ready_i) begin
                        v_q         <= 1'b0;
                        state_q     <= S_FILL;
                        group_cnt_q <= group_cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    assign content_o          = content_q;
    assign key_o              = key_q;
    assign encode_or_decode_o = enc_q;
    assign v_o                = v_q;
    assign invalid_cache_o    = inv_q;
    assign padded_o           = padded_q;
    assign group_cnt_o        = group_cnt_q;

endmodule

// File: tb/tb_sm4_group_packer.sv
// Directed bench for sm4_group_packer: key load, full/short groups,
// backpressure, key/data priority, key reload, reset and counter wrap.
module tb_sm4_group_packer;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [31:0]  word_i;
    logic         word_v_i, word_last_i, mode_i, word_ready_o;
    logic [31:0]  key_word_i;
    logic         key_word_v_i, key_word_ready_o;
    logic [127:0] content_o, key_o;
    logic         encode_or_decode_o, v_o, ready_i, invalid_cache_o, padded_o;
    logic [7:0]   group_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    sm4_group_packer dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .word_i             (word_i),
        .word_v_i           (word_v_i),
        .word_last_i        (word_last_i),
        .mode_i             (mode_i),
        .word_ready_o       (word_ready_o),
        .key_word_i         (key_word_i),
        .key_word_v_i       (key_word_v_i),
        .key_word_ready_o   (key_word_ready_o),
        .content_o          (content_o),
        .key_o              (key_o),
        .encode_or_decode_o (encode_or_decode_o),
        .v_o                (v_o),
        .ready_i            (ready_i),
        .invalid_cache_o    (invalid_cache_o),
        .padded_o           (padded_o),
        .group_cnt_o        (group_cnt_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put_key(input logic [31:0] w);
        key_word_v_i = 1'b1;
        key_word_i   = w;
        #1;
        chk("key_ready", key_word_ready_o, 1);
        tick();
        key_word_v_i = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] w, input logic last, input logic m);
        word_v_i    = 1'b1;
        word_i      = w;
        word_last_i = last;
        mode_i      = m;
        #1;
        chk("word_ready", word_ready_o, 1);
        tick();
        word_v_i    = 1'b0;
        word_last_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b0; word_i = '0; word_v_i = 0; word_last_i = 0; mode_i = 0;
        key_word_i = '0; key_word_v_i = 0; ready_i = 0;
        tick(); tick();
        chk("rst_v", v_o, 0);
        chk("rst_key", key_o, 0);
        chk("rst_content", content_o, 0);
        chk("rst_cnt", group_cnt_o, 0);
        chk("rst_inv", invalid_cache_o, 0);
        chk("rst_pad", padded_o, 0);
        reset_i = 1'b1;

        // data before any key is stalled
        word_v_i = 1'b1; word_i = 32'hdead_beef;
        #1; chk("nokey_ready", word_ready_o, 0);
        tick(); chk("nokey_ready2", word_ready_o, 0);

        // simultaneous key and data: key wins
        key_word_v_i = 1'b1; key_word_i = 32'h0123_4567;
        #1;
        chk("prio_key_ready", key_word_ready_o, 1);
        chk("prio_word_ready", word_ready_o, 0);
        tick();
        key_word_v_i = 1'b0; word_v_i = 1'b0;
        put_key(32'h89ab_cdef);
        put_key(32'hfedc_ba98);
        chk("key_before_4th", key_o, 0);
        chk("inv_before", invalid_cache_o, 0);
        put_key(32'h7654_3210);
        chk("key_loaded", key_o, 128'h0123456789abcdeffedcba9876543210);
        chk("inv_pulse", invalid_cache_o, 1);
        tick();
        chk("inv_one_cycle", invalid_cache_o, 0);
        #1; chk("word_ready_after_key", word_ready_o, 1);

        // full group, then backpressure
        put_word(32'h0123_4567, 0, 0);
        put_word(32'h89ab_cdef, 0, 1);
        put_word(32'hfedc_ba98, 0, 1);
        chk("v_before_close", v_o, 0);
        put_word(32'h7654_3210, 0, 1);
        chk("full_v", v_o, 1);
        chk("full_content", content_o, 128'h0123456789abcdeffedcba9876543210);
        chk("full_mode", encode_or_decode_o, 0);
        chk("full_pad", padded_o, 0);
        chk("send_word_ready", word_ready_o, 0);
        chk("send_key_ready", key_word_ready_o, 0);
        repeat (10) tick();
        chk("bp_v", v_o, 1);
        chk("bp_content", content_o, 128'h0123456789abcdeffedcba9876543210);
        chk("bp_word_ready", word_ready_o, 0);
        chk("bp_cnt", group_cnt_o, 0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("handoff_v", v_o, 0);
        chk("handoff_cnt", group_cnt_o, 1);

        // short group, mode from first word
        put_word(32'haabb_ccdd, 0, 1);
        put_word(32'h1122_3344, 1, 0);
        chk("short_v", v_o, 1);
        chk("short_content", content_o, 128'haabbccdd112233440000000000000000);
        chk("short_pad", padded_o, 1);
        chk("short_mode", encode_or_decode_o, 1);
        ready_i = 1'b1; tick(); ready_i = 1'b0;
        chk("short_cnt", group_cnt_o, 2);

        // last on the fourth word is not padding
        put_word(32'h0000_0001, 0, 0);
        put_word(32'h0000_0002, 0, 0);
        put_word(32'h0000_0003, 0, 0);
        put_word(32'h0000_0004, 1, 0);
        chk("last4_content", content_o, 128'h00000001000000020000000300000004);
        chk("last4_pad", padded_o, 0);
        ready_i = 1'b1; tick(); ready_i = 1'b0;
        chk("last4_cnt", group_cnt_o, 3);

        // key reload keeps old key until complete
        put_key(32'ha0a1_a2a3);
        put_key(32'hb0b1_b2b3);
        #1;
        chk("reload_stall", word_ready_o, 0);
        chk("reload_old_key", key_o, 128'h0123456789abcdeffedcba9876543210);
        put_key(32'hc0c1_c2c3);
        put_key(32'hd0d1_d2d3);
        chk("reload_key", key_o, 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3);
        chk("reload_inv", invalid_cache_o, 1);

        // reset mid-group
        put_word(32'h5555_5555, 0, 0);
        put_word(32'h6666_6666, 0, 0);
        reset_i = 1'b0;
        tick();
        chk("mid_rst_v", v_o, 0);
        chk("mid_rst_key", key_o, 0);
        chk("mid_rst_content", content_o, 0);
        chk("mid_rst_cnt", group_cnt_o, 0);
        reset_i = 1'b1;
        word_v_i = 1'b1;
        #1; chk("mid_rst_keyloaded", word_ready_o, 0);
        word_v_i = 1'b0;

        // counter wrap after 256 groups
        put_key(32'h1); put_key(32'h2); put_key(32'h3); put_key(32'h4);
        ready_i = 1'b1;
        for (int i = 0; i < 256; i++) begin
            put_word(i, 1, 0);
            tick();
            if (i == 254) chk("cnt_255", group_cnt_o, 255);
        end
        chk("cnt_wrap", group_cnt_o, 0);
        ready_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
